// File: rtl/sys_bus_pkg.sv
// Shared system-bus definitions: T-phase encoding, default widths and the
// per-phase strobe windows used by bus initiators.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2,
    T4 = 2'd3
  } tphase_e;

  localparam int ADDR_W_DEF   = 32'sd16;
  localparam int DATA_W_DEF   = 32'sd8;
  localparam int MAX_WAIT_DEF = 32'sd15;

  // Window masks: bit n set means the strobe is active in phase n.
  localparam logic [3:0] RD_WIN   = 4'b0110;
  localparam logic [3:0] SYNC_WIN = 4'b1100;
  localparam logic [3:0] WE_WIN   = 4'b1110;

  function automatic logic in_window(input logic [3:0] win, input logic [1:0] ph);
    return win[ph];
  endfunction

endpackage

// File: rtl/bus_phase_counter.sv
// Free-running T1..T4 phase register with a hold input (used for bus stalls)
// and a T4 decode marking the edge that ends a machine cycle.
module bus_phase_counter
  import sys_bus_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       hold,
  output logic [1:0] phase_r,
  output logic [1:0] phase_nxt_s,
  output logic       is_t4_s
);

  // Next phase: stay put while held, otherwise wrap T4 back to T1.
  always_comb begin
    phase_nxt_s = phase_r;
    if (hold) begin
      phase_nxt_s = phase_r;
    end else begin
      phase_nxt_s = phase_r + 2'd1;
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      phase_r <= T1;
    end else begin
      phase_r <= phase_nxt_s;
    end
  end

  assign is_t4_s = (phase_r == T4);

endmodule

// File: rtl/cpu_bus_master.sv
// CPU-side initiator turning single core requests into T1-T4 bus cycles.
// Defining BUS_MASTER_WAIT_EN adds nwait stalling in T3 with a timeout.
module cpu_bus_master
  import sys_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef BUS_MASTER_WAIT_EN
  ,
  parameter int MAX_WAIT = MAX_WAIT_DEF
`endif
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] a,
  output logic              cpu_raw_rd,
  output logic              cpu_wr_raw,
  output logic              cpu_rd_sync,
  output logic [DATA_W-1:0] d_out,
  output logic              d_oe,
  input  logic [DATA_W-1:0] d_in,
  output logic [1:0]        tphase
`ifdef BUS_MASTER_WAIT_EN
  ,
  input  logic              nwait,
  output logic              wait_to
`endif
);

  logic [1:0]        phase_r;
  logic [1:0]        phase_nxt_s;
  logic              is_t4_s;
  logic              hold_s;
  logic              leave_t3_s;
  logic              active_r;
  logic              we_r;
  logic              active_nxt_s;
  logic              we_nxt_s;
  logic              load_s;
  logic [ADDR_W-1:0] a_r;
  logic [DATA_W-1:0] d_out_r;
  logic [DATA_W-1:0] rdata_r;
  logic              raw_rd_r;
  logic              wr_raw_r;
  logic              rd_sync_r;
  logic              d_oe_r;
  logic              ack_r;

  bus_phase_counter u_phase (
    .clk         (clk),
    .nreset      (nreset),
    .hold        (hold_s),
    .phase_r     (phase_r),
    .phase_nxt_s (phase_nxt_s),
    .is_t4_s     (is_t4_s)
  );

`ifdef BUS_MASTER_WAIT_EN
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] stall_cnt_r;
  logic       in_t3_s;
  logic       timeout_s;
  logic       wait_to_r;

  // Stall decision: only an active T3 honours nwait, until the budget runs out.
  always_comb begin
    in_t3_s   = 1'b0;
    timeout_s = 1'b0;
    hold_s    = 1'b0;
    if (active_r && (phase_r == T3)) begin
      in_t3_s   = 1'b1;
      timeout_s = (stall_cnt_r == MAX_WAIT_C);
      hold_s    = !nwait && !timeout_s;
    end else begin
      in_t3_s   = 1'b0;
      timeout_s = 1'b0;
      hold_s    = 1'b0;
    end
  end

  // Stall counter and timeout flag; the flag lands in T4 next to ack.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stall_cnt_r <= 4'd0;
      wait_to_r   <= 1'b0;
    end else begin
      stall_cnt_r <= hold_s ? (stall_cnt_r + 4'd1) : 4'd0;
      wait_to_r   <= in_t3_s && timeout_s;
    end
  end

  assign wait_to = wait_to_r;
`else
  assign hold_s = 1'b0;
`endif

  // Request capture happens only on the edge that ends T4.
  always_comb begin
    load_s       = 1'b0;
    active_nxt_s = active_r;
    we_nxt_s     = we_r;
    leave_t3_s   = (phase_r == T3) && !hold_s;
    if (is_t4_s) begin
      load_s       = req;
      active_nxt_s = req;
      we_nxt_s     = req ? we : we_r;
    end else begin
      load_s       = 1'b0;
      active_nxt_s = active_r;
      we_nxt_s     = we_r;
    end
  end

  // Cycle state plus all bus outputs, registered from next-cycle values so
  // every strobe lines up with the phase it belongs to.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      active_r  <= 1'b0;
      we_r      <= 1'b0;
      a_r       <= '0;
      d_out_r   <= '0;
      rdata_r   <= '0;
      raw_rd_r  <= 1'b0;
      wr_raw_r  <= 1'b0;
      rd_sync_r <= 1'b0;
      d_oe_r    <= 1'b0;
      ack_r     <= 1'b0;
    end else begin
      active_r  <= active_nxt_s;
      we_r      <= we_nxt_s;
      raw_rd_r  <= active_nxt_s && !we_nxt_s && in_window(RD_WIN, phase_nxt_s);
      rd_sync_r <= active_nxt_s && !we_nxt_s && in_window(SYNC_WIN, phase_nxt_s);
      wr_raw_r  <= active_nxt_s && we_nxt_s && in_window(RD_WIN, phase_nxt_s);
      d_oe_r    <= active_nxt_s && we_nxt_s && in_window(WE_WIN, phase_nxt_s);
      ack_r     <= active_nxt_s && (phase_nxt_s == T4);
      if (load_s) begin
        a_r <= addr;
      end
      if (load_s && we) begin
        d_out_r <= wdata;
      end
      if (leave_t3_s && active_r && !we_r) begin
        rdata_r <= d_in;
      end
    end
  end

  assign tphase      = phase_r;
  assign a           = a_r;
  assign d_out       = d_out_r;
  assign rdata       = rdata_r;
  assign cpu_raw_rd  = raw_rd_r;
  assign cpu_wr_raw  = wr_raw_r;
  assign cpu_rd_sync = rd_sync_r;
  assign d_oe        = d_oe_r;
  assign ack         = ack_r;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Randomised bench for cpu_bus_master against a transaction-level model of
// the T1-T4 bus cycle; exercises stalls when BUS_MASTER_WAIT_EN is defined.
module tb_cpu_bus_master;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int MAXW = 15;

  logic          clk = 1'b0;
  logic          nreset;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  logic [AW-1:0] a;
  logic          cpu_raw_rd;
  logic          cpu_wr_raw;
  logic          cpu_rd_sync;
  logic [DW-1:0] d_out;
  logic          d_oe;
  logic [DW-1:0] d_in;
  logic [1:0]    tphase;
`ifdef BUS_MASTER_WAIT_EN
  logic          nwait;
  logic          wait_to;
  localparam bit WAIT_ON = 1'b1;
`else
  localparam bit WAIT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu_bus_master #(
    .ADDR_W   (AW),
    .DATA_W   (DW)
`ifdef BUS_MASTER_WAIT_EN
    ,
    .MAX_WAIT (MAXW)
`endif
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata),
    .a           (a),
    .cpu_raw_rd  (cpu_raw_rd),
    .cpu_wr_raw  (cpu_wr_raw),
    .cpu_rd_sync (cpu_rd_sync),
    .d_out       (d_out),
    .d_oe        (d_oe),
    .d_in        (d_in),
    .tphase      (tphase)
`ifdef BUS_MASTER_WAIT_EN
    ,
    .nwait       (nwait),
    .wait_to     (wait_to)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: state of the current bus cycle at transaction level.
  int            ph_m;
  int            stall_m;
  bit            act_m;
  bit            we_m;
  bit            to_m;
  logic [AW-1:0] a_m;
  logic [DW-1:0] dout_m;
  logic [DW-1:0] rdata_m;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph_m = 0; stall_m = 0; act_m = 1'b0; we_m = 1'b0; to_m = 1'b0;
    a_m = '0; dout_m = '0; rdata_m = '0;
  endtask

  task automatic check_outputs();
    bit rd;
    bit wr;
    rd = act_m && !we_m;
    wr = act_m && we_m;
    check_val("ctl", {25'd0, tphase, cpu_raw_rd, cpu_rd_sync, cpu_wr_raw, d_oe, ack},
              {25'd0, 2'(ph_m), rd && (ph_m == 1 || ph_m == 2), rd && (ph_m >= 2),
               wr && (ph_m == 1 || ph_m == 2), wr && (ph_m >= 1), act_m && (ph_m == 3)});
    check_val("a", {16'd0, a}, {16'd0, a_m});
    check_val("d_out", {24'd0, d_out}, {24'd0, dout_m});
    check_val("rdata", {24'd0, rdata}, {24'd0, rdata_m});
`ifdef BUS_MASTER_WAIT_EN
    check_val("wait_to", {31'd0, wait_to}, {31'd0, act_m && (ph_m == 3) && to_m});
`endif
  endtask

  // One clock: check at the negedge, drive inputs (noise except where it
  // matters), cross the posedge, advance the model, return to a negedge.
  task automatic tick(input logic t4_req, input logic t4_we, input logic [AW-1:0] t4_addr,
                      input logic [DW-1:0] t4_wdata, input logic [DW-1:0] t3_din, input logic nw);
    check_outputs();
    if (ph_m == 3) begin
      req = t4_req; we = t4_we; addr = t4_addr; wdata = t4_wdata;
    end else begin
      req = 1'($urandom); we = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
    end
    d_in = (ph_m == 2) ? t3_din : 8'($urandom);
`ifdef BUS_MASTER_WAIT_EN
    nwait = (ph_m == 2) ? nw : 1'($urandom);
`endif
    @(posedge clk);
    if (ph_m == 2) begin
      if (WAIT_ON && act_m && !nw && stall_m < MAXW) begin
        stall_m++;
      end else begin
        to_m = WAIT_ON && act_m && (stall_m == MAXW);
        if (act_m && !we_m) rdata_m = t3_din;
        stall_m = 0;
        ph_m = 3;
      end
    end else if (ph_m == 3) begin
      if (t4_req) begin
        a_m = t4_addr; we_m = t4_we;
        if (t4_we) dout_m = t4_wdata;
      end
      act_m = t4_req; to_m = 1'b0; ph_m = 0;
    end else begin
      ph_m++;
    end
    @(negedge clk);
  endtask

  // Runs the remainder of the current bus cycle; rq/w/ad/wd become the request
  // presented in its T4, din is the read data offered in T3, and nwait is held
  // low for the first n_stall clocks of T3.
  task automatic run_slot(input logic rq, input logic w, input logic [AW-1:0] ad,
                          input logic [DW-1:0] wd, input logic [DW-1:0] din, input int n_stall);
    int k;
    int guard;
    logic nw;
    k = 0;
    guard = 0;
    do begin
      nw = 1'b1;
      if (ph_m == 2) begin
        nw = (k < n_stall) ? 1'b0 : 1'b1;
        k++;
      end
      tick(rq, w, ad, wd, din, nw);
      guard++;
    end while (ph_m != 0 && guard < 40);
    if (guard >= 40) check_val("slot_bound", guard, 32'd0);
  endtask

  initial begin
    nreset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; d_in = '0;
`ifdef BUS_MASTER_WAIT_EN
    nwait = 1'b1;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    nreset = 1'b1;

    // Idle cycles straight out of reset.
    repeat (3) run_slot(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 0);

    // Single read then single write.
    run_slot(1'b1, 1'b0, 16'hFF0F, 8'h00, 8'h00, 0);
    run_slot(1'b0, 1'b0, 16'h0000, 8'h00, 8'hE1, 0);
    check_val("rd_ff0f", {24'd0, rdata}, 32'h0000_00E1);
    run_slot(1'b1, 1'b1, 16'hFF50, 8'h01, 8'h00, 0);
    run_slot(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 0);
    check_val("wr_ff50", {8'd0, a, d_out}, 32'h00FF_5001);

    // Back-to-back reads with req held high.
    run_slot(1'b1, 1'b0, 16'hFF80, 8'h00, 8'h00, 0);
    run_slot(1'b1, 1'b0, 16'hFFFE, 8'h00, 8'hA5, 0);
    run_slot(1'b0, 1'b0, 16'h0000, 8'h00, 8'h3C, 0);

    // Reset pulsed in the middle of a write's T3.
    run_slot(1'b1, 1'b1, 16'hC000, 8'h77, 8'h00, 0);
    tick(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b1);
    tick(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b1);
    check_val("wr_t3", {30'd0, cpu_wr_raw, d_oe}, 32'd3);
    #2 nreset = 1'b0;
    #1 check_val("rst_async", {27'd0, cpu_wr_raw, d_oe, ack, cpu_raw_rd, cpu_rd_sync}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    model_reset();
    run_slot(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 0);

`ifdef BUS_MASTER_WAIT_EN
    // Short stall, then a stall that runs into the timeout.
    run_slot(1'b1, 1'b0, 16'h1234, 8'h00, 8'h00, 0);
    run_slot(1'b1, 1'b1, 16'h4321, 8'h5A, 8'h9A, 3);
    check_val("rd_stall", {24'd0, rdata}, 32'h0000_009A);
    run_slot(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 40);
`endif

    // Randomised traffic.
    for (int i = 0; i < 80; i++) begin
      run_slot(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
               WAIT_ON ? int'($urandom_range(0, 18)) : 0);
    end
    run_slot(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
